// File: rtl/mandel_pkg.sv
// -----------------------------------------------------------------------------
// mandel_pkg
// Shared definitions for the Mandelbrot escape-time engine: the signed Q11.21
// fixed-point word, its full-precision Q22.42 product, common constants and
// the iterator FSM state encoding.
// -----------------------------------------------------------------------------
package mandel_pkg;

    localparam int FRAC   = 21;
    localparam int WORD_W = 32;
    localparam int PROD_W = 2 * WORD_W;

    typedef logic signed [WORD_W-1:0] q21_t;
    typedef logic signed [PROD_W-1:0] q42_t;

    localparam q21_t ONE  = 32'sh0020_0000;
    localparam q21_t TWO  = ONE <<< 1;
    localparam q21_t FOUR = TWO <<< 1;

    // 4.0 in the Q22.42 domain of a squared magnitude (4 << 2*FRAC), 65 bits
    // wide so the sum of two non-negative products can be compared directly.
    localparam logic [PROD_W:0] ESCAPE_THRESH = (PROD_W+1)'(FOUR) << FRAC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mandel_iterator_if.sv
// -----------------------------------------------------------------------------
// mandel_iterator_if
// Point-in / result-out handshake bundle of the escape-time engine.
//   in_*  : upstream point (valid/ready, c = in_re + i*in_im, pixel x/y)
//   out_* : downstream result (valid/ready, iteration count, pixel x/y)
// Modports: master = producer of points / consumer of results,
//           slave  = the engine.
// -----------------------------------------------------------------------------
interface mandel_iterator_if
    import mandel_pkg::*;
#(
    parameter int ITER_W = 8
);
    logic              in_valid;
    logic              in_ready;
    q21_t              in_re;
    q21_t              in_im;
    logic [9:0]        in_x;
    logic [9:0]        in_y;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic [9:0]        out_x;
    logic [9:0]        out_y;

    modport master (
        output in_valid, in_re, in_im, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_iter, out_x, out_y
    );

    modport slave (
        input  in_valid, in_re, in_im, in_x, in_y, out_ready,
        output in_ready, out_valid, out_iter, out_x, out_y
    );
endinterface

// File: rtl/mandel_iterator_fx_mul.sv
// -----------------------------------------------------------------------------
// fx_mul_q21
// Combinational signed Q11.21 x Q11.21 multiplier.
//   a, b      : signed Q11.21 operands
//   prod_full : exact signed 64-bit product (Q22.42)
//   prod_q21  : product truncated back to Q11.21 (bits [52:21], i.e. an
//               arithmetic shift right by FRAC with no rounding; the integer
//               part wraps)
// -----------------------------------------------------------------------------
module fx_mul_q21
    import mandel_pkg::*;
(
    input  q21_t a,
    input  q21_t b,
    output q42_t prod_full,
    output q21_t prod_q21
);

    // Operands are sign-extended to 64 bits first so the product is exact.
    assign prod_full = q42_t'(a) * q42_t'(b);
    assign prod_q21  = prod_full[FRAC+WORD_W-1:FRAC];

endmodule

// File: rtl/mandel_iterator.sv
// -----------------------------------------------------------------------------
// mandel_iterator
// Per-pixel Mandelbrot escape-time engine. Accepts one point c, iterates
// z <- z^2 + c at one iteration per clock and returns the iteration count at
// which |z|^2 first exceeds 4.0 (or MAX_ITER) together with the pixel x/y.
//   aclk    : clock, rising edge
//   aresetn : asynchronous active-low reset; discards any point in flight
//   bus     : mandel_iterator_if.slave (point in, result out)
// Accept-to-result latency for a result n is n+2 cycles.
// -----------------------------------------------------------------------------
module mandel_iterator
    import mandel_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
)(
    input  logic                   aclk,
    input  logic                   aresetn,
    mandel_iterator_if.slave       bus
);

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_e            state_r,     state_nxt;
    q21_t              c_re_r,      c_re_nxt;
    q21_t              c_im_r,      c_im_nxt;
    q21_t              z_re_r,      z_re_nxt;
    q21_t              z_im_r,      z_im_nxt;
    logic [ITER_W-1:0] count_r,     count_nxt;
    logic [ITER_W-1:0] out_iter_r,  out_iter_nxt;
    logic [9:0]        out_x_r,     out_x_nxt;
    logic [9:0]        out_y_r,     out_y_nxt;
    logic              in_ready_r,  in_ready_nxt;
    logic              out_valid_r, out_valid_nxt;

    q42_t              zr2_full_s;
    q42_t              zi2_full_s;
    q42_t              zri_full_unused_s;
    q21_t              zr2_q21_s;
    q21_t              zi2_q21_s;
    q21_t              zri_q21_s;
    logic [PROD_W:0]   mag_s;
    logic              escape_s;

    fx_mul_q21 u_mul_zr2 (.a(z_re_r), .b(z_re_r), .prod_full(zr2_full_s),        .prod_q21(zr2_q21_s));
    fx_mul_q21 u_mul_zi2 (.a(z_im_r), .b(z_im_r), .prod_full(zi2_full_s),        .prod_q21(zi2_q21_s));
    fx_mul_q21 u_mul_zri (.a(z_re_r), .b(z_im_r), .prod_full(zri_full_unused_s), .prod_q21(zri_q21_s));

    // Squares are non-negative, so the magnitude is summed unsigned with a
    // carry bit; exactly 4.0 does not count as an escape.
    assign mag_s    = {1'b0, zr2_full_s} + {1'b0, zi2_full_s};
    assign escape_s = (mag_s > ESCAPE_THRESH);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_iter  = out_iter_r;
    assign bus.out_x     = out_x_r;
    assign bus.out_y     = out_y_r;

    // Next-state and datapath update for the IDLE / ITER / DONE sequence.
    always_comb begin
        state_nxt     = state_r;
        c_re_nxt      = c_re_r;
        c_im_nxt      = c_im_r;
        z_re_nxt      = z_re_r;
        z_im_nxt      = z_im_r;
        count_nxt     = count_r;
        out_iter_nxt  = out_iter_r;
        out_x_nxt     = out_x_r;
        out_y_nxt     = out_y_r;
        in_ready_nxt  = in_ready_r;
        out_valid_nxt = out_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    c_re_nxt     = bus.in_re;
                    c_im_nxt     = bus.in_im;
                    out_x_nxt    = bus.in_x;
                    out_y_nxt    = bus.in_y;
                    z_re_nxt     = '0;
                    z_im_nxt     = '0;
                    count_nxt    = '0;
                    in_ready_nxt = 1'b0;
                    state_nxt    = ST_ITER;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ITER: begin
                // Escape is tested on the current z, before this cycle's update.
                if (escape_s || (count_r == MAX_CNT)) begin
                    out_iter_nxt  = count_r;
                    out_valid_nxt = 1'b1;
                    state_nxt     = ST_DONE;
                end else begin
                    // 32-bit wrap on overflow is intentional.
                    z_re_nxt  = zr2_q21_s - zi2_q21_s + c_re_r;
                    z_im_nxt  = (zri_q21_s <<< 1) + c_im_r;
                    count_nxt = count_r + ITER_W'(1);
                end
            end
            ST_DONE: begin
                // in_ready returns one cycle after the result handshake.
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                in_ready_nxt  = 1'b1;
                state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any point in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            c_re_r      <= '0;
            c_im_r      <= '0;
            z_re_r      <= '0;
            z_im_r      <= '0;
            count_r     <= '0;
            out_iter_r  <= '0;
            out_x_r     <= 10'd0;
            out_y_r     <= 10'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            c_re_r      <= c_re_nxt;
            c_im_r      <= c_im_nxt;
            z_re_r      <= z_re_nxt;
            z_im_r      <= z_im_nxt;
            count_r     <= count_nxt;
            out_iter_r  <= out_iter_nxt;
            out_x_r     <= out_x_nxt;
            out_y_r     <= out_y_nxt;
            in_ready_r  <= in_ready_nxt;
            out_valid_r <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mandel_iterator.sv
// -----------------------------------------------------------------------------
// tb_mandel_iterator
// Directed self-checking bench for mandel_iterator: hand-computed escape
// counts, accept-to-result latency, back-pressure stability, busy-input
// rejection and reset mid-iteration.
// -----------------------------------------------------------------------------
module tb_mandel_iterator;
    import mandel_pkg::*;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    mandel_iterator_if #(.ITER_W(8)) bus ();

    mandel_iterator #(.MAX_ITER(255), .ITER_W(8)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Present one point, wait for its result, optionally stall the result,
    // then complete the result handshake. With busy_poke the input stays
    // valid with altered data during iteration to show it is ignored.
    task automatic run_point(input string name, input logic [31:0] re, input logic [31:0] im,
                             input logic [9:0] x, input logic [9:0] y, input int exp_iter,
                             input int stall, input bit busy_poke);
        int lat;
        bit seen;
        bit stable;
        bit rdy_low;
        @(negedge aclk);
        bus.in_re     = re;
        bus.in_im     = im;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        check({name, ":ready_idle"}, bus.in_ready, 1);
        @(posedge aclk);
        lat  = 1;
        seen = 1'b0;
        @(negedge aclk);
        check({name, ":ready_busy"}, bus.in_ready, 0);
        if (busy_poke) begin
            bus.in_x  = 10'd99;
            bus.in_re = 32'h0000_0000;
        end else begin
            bus.in_valid = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge aclk);
            lat++;
            @(negedge aclk);
        end
        bus.in_valid = 1'b0;
        check({name, ":result_seen"}, seen, 1);
        check({name, ":latency"}, lat, exp_iter + 2);
        check({name, ":iter"}, bus.out_iter, exp_iter);
        check({name, ":x"}, bus.out_x, x);
        check({name, ":y"}, bus.out_y, y);
        stable  = 1'b1;
        rdy_low = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge aclk);
            @(negedge aclk);
            if (bus.out_valid !== 1'b1 || bus.out_iter !== 8'(exp_iter) ||
                bus.out_x !== x || bus.out_y !== y) stable = 1'b0;
            if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
        end
        if (stall > 0) begin
            check({name, ":stall_stable"}, stable, 1);
            check({name, ":stall_ready_low"}, rdy_low, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check({name, ":valid_cleared"}, bus.out_valid, 0);
        check({name, ":ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        bit late_valid;
        bus.in_valid  = 1'b0;
        bus.in_re     = 32'h0;
        bus.in_im     = 32'h0;
        bus.in_x      = 10'd0;
        bus.in_y      = 10'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge aclk);
        check("reset:in_ready", bus.in_ready, 1);
        check("reset:out_valid", bus.out_valid, 0);
        check("reset:out_iter", bus.out_iter, 0);
        check("reset:out_x", bus.out_x, 0);
        check("reset:out_y", bus.out_y, 0);
        aresetn = 1'b1;

        run_point("c0",   32'h0000_0000, 32'h0000_0000, 10'd5,  10'd7,  255, 0,  1'b0);
        run_point("c3",   32'h0060_0000, 32'h0000_0000, 10'd1,  10'd2,  1,   0,  1'b1);
        run_point("c2",   32'h0040_0000, 32'h0000_0000, 10'd11, 10'd12, 2,   0,  1'b0);
        run_point("cm2",  32'hFFC0_0000, 32'h0000_0000, 10'd13, 10'd14, 255, 0,  1'b0);
        run_point("ci2",  32'h0000_0000, 32'h0040_0000, 10'd15, 10'd16, 2,   20, 1'b0);

        // Reset in the middle of iterating c = 0.
        @(negedge aclk);
        bus.in_re    = 32'h0;
        bus.in_im    = 32'h0;
        bus.in_x     = 10'd3;
        bus.in_y     = 10'd4;
        bus.in_valid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.in_valid = 1'b0;
        repeat (40) @(negedge aclk);
        check("midrst:busy_x", bus.out_x, 3);
        aresetn = 1'b0;
        #1;
        check("midrst:out_valid", bus.out_valid, 0);
        check("midrst:in_ready", bus.in_ready, 1);
        check("midrst:out_iter", bus.out_iter, 0);
        check("midrst:out_x", bus.out_x, 0);
        check("midrst:out_y", bus.out_y, 0);
        @(negedge aclk);
        aresetn    = 1'b1;
        late_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (bus.out_valid) late_valid = 1'b1;
        end
        check("midrst:no_result", late_valid, 0);

        run_point("c3b",  32'h0060_0000, 32'h0000_0000, 10'd21, 10'd22, 1,   0,  1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mandel_iterator.md
Name: mandel_iterator

Overview:
Per-pixel Mandelbrot escape-time engine, directly downstream of the pixel-to-complex-plane mapper.
- Accepts one point c = (re, im) in signed Q11.21, plus its pixel coordinates (x, y), over a valid/ready handshake.
- Iterates z <- z^2 + c at one iteration per clock and returns the escape iteration count with the pixel coordinates.
- The result feeds the colour/framebuffer writer.

Parameters:
MAX_ITER, 255, iteration cap; a point that has not escaped after MAX_ITER iterations reports MAX_ITER.
ITER_W, 8, width of the iteration counter/result; must satisfy MAX_ITER <= 2^ITER_W - 1.
FRAC, 21, fraction bits of the 32-bit signed fixed-point format (Q11.21).

Ports:
aclk  in  1  clock; all state updates on rising edge
aresetn  in  1  asynchronous, active-low reset
in_valid  in  1  point available on in_re/in_im/in_x/in_y
in_ready  out  1  engine can accept a point
in_re  in  32  real part of c, signed Q11.21
in_im  in  32  imaginary part of c, signed Q11.21
in_x  in  10  pixel column, passed through
in_y  in  10  pixel row, passed through
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_iter  out  ITER_W  escape iteration count
out_x  out  10  pixel column of the result
out_y  out  10  pixel row of the result

Behaviour:
- Reset (asynchronous, aresetn low):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_iter, out_x, out_y, z_re, z_im, c, count all = 0.
  - Reset mid-iteration discards the point; no result is produced.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch c, x, y; z_re = z_im = 0; count = 0; go to ITER.
- ITER:
  - in_ready = 0.
  - Each cycle, compute full-precision 64-bit signed products: zr2 = z_re*z_re, zi2 = z_im*z_im, zri = z_re*z_im (all Q22.42).
  - Escape test on the current z, before update: mag = zr2 + zi2 (65-bit, unsigned); escape iff mag > 4.0, i.e. mag > (4 << 42). Exactly 4.0 does not escape.
  - If escape, or count == MAX_ITER: out_iter = count; go to DONE.
  - Otherwise, with each product truncated to bits [52:21] (Q11.21, arithmetic shift, no rounding):
    - z_re <= trunc(zr2) - trunc(zi2) + c_re
    - z_im <= (trunc(zri) << 1) + c_im
    - count <= count + 1
  - Overflow in the z update wraps in 32 bits; no saturation. It cannot occur for |c| < 1000 because the escape test bounds |z| <= 2.
- DONE:
  - out_valid = 1; out_iter, out_x, out_y held stable until out_ready.
  - On out_valid && out_ready: out_valid = 0; go to IDLE. in_ready rises the following cycle (no same-cycle turnaround).
- Latency:
  - Handshake in cycle T with result n gives n+1 cycles in ITER.
  - out_valid first high in cycle T+n+2.
  - Back-pressure (out_ready low) extends DONE indefinitely with no change to outputs.
- Boundary conditions:
  - in_valid while busy is ignored; upstream must hold the point until in_ready.
  - count never exceeds MAX_ITER.
  - MAX_ITER = 0 returns 0 for every point.

Decomposition:
- Shared package mandel_pkg holds:
  - FRAC, WORD_W = 32, ESCAPE_THRESH = 4 << (2*FRAC), the Q11.21 fixed-point type, and fixed-point constants ONE/TWO/FOUR.
- One natural sub-module: fx_mul_q21 (signed 32x32 -> 64 full product plus Q11.21 truncated output).
  - Instantiated three times for zr2, zi2, zri.
- FSM, counter and handshake live in mandel_iterator.

Test Plan:
- c = 0 + 0i (0x00000000, 0x00000000), x = 5, y = 7 -> out_iter = 255, out_x = 5, out_y = 7; out_valid first high 257 cycles after the accept cycle.
- c = 3.0 + 0i (in_re = 0x00600000) -> out_iter = 1; out_valid high in cycle T+3.
- c = 2.0 + 0i (0x00400000) -> out_iter = 2 (|z1|^2 = 4.0 is not an escape; z2 = 6 escapes).
- c = -2.0 + 0i (0xFFC00000) -> orbit 0, -2, 2, 2, ... never exceeds 4 -> out_iter = 255.
- c = 0 + 2.0i (in_im = 0x00400000), out_ready held low 20 cycles after out_valid:
  - out_iter = 2 (z1 = 2i, |z1|^2 = 4 no escape; z2 = -4 + 2i escapes).
  - Outputs stable, in_ready stays 0 throughout the stall, in_ready = 1 the cycle after out_ready.
- c = 0 + 0i accepted, aresetn pulsed low mid-ITER (count ~ 40) -> outputs/state zero immediately, in_ready = 1, no out_valid afterward; next point c = 3.0 returns out_iter = 1.
